col_burst_collector: RTL and testbench

COL_BURST_COLLECTOR -- requirements
Module: col_burst_collector

---
 rtl/img2col_pkg.sv | 15 +
 rtl/col_bank.sv | 29 ++
 rtl/col_burst_collector.sv | 158 +++++++++++++++
 tb/tb_col_burst_collector.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// Shared types and default geometry for the img2col column collector.
package img2col_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_GAP     = 2'd3
    } col_state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_COL_LEN = 27;
    localparam int DEF_MIN_GAP = 3;

endpackage

// File: rtl/col_bank.sv
// One column bank: indexed single-element write, whole column read in parallel.
module col_bank
    import img2col_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COL_LEN = DEF_COL_LEN,
    parameter int ADDR_W  = $clog2(DEF_COL_LEN)
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_data,
    output logic [COL_LEN*DATA_W-1:0] o_data
);

    // Storage is deliberately not reset; contents only matter once marked full.
    logic [DATA_W-1:0] r_mem [COL_LEN];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_data;
        end
    end

    for (genvar g = 0; g < COL_LEN; g++) begin : g_out
        assign o_data[g*DATA_W +: DATA_W] = r_mem[g];
    end

endmodule

// File: rtl/col_burst_collector.sv
// Collects flag-strobed element bursts into columns held in two ping-pong banks.
module col_burst_collector
    import img2col_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COL_LEN = DEF_COL_LEN,
    parameter int MIN_GAP = DEF_MIN_GAP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      map_finish,
    input  logic                      flag_in,
    input  logic [DATA_W-1:0]         data_in,
    output logic [COL_LEN*DATA_W-1:0] col_data,
    output logic                      col_valid,
    input  logic                      col_ready,
    output logic [15:0]               col_count,
    output logic                      short_err,
    output logic                      gap_err,
    output logic                      ovf_err,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int CNT_W = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COL_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(MIN_GAP);

    col_state_t         r_state;
    logic [CNT_W-1:0]   r_elem_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               r_drop;
    logic [1:0]         r_full;
    logic [15:0]        r_col_count;
    logic               r_short_err;
    logic               r_gap_err;
    logic               r_ovf_err;

    logic               w_burst_start;
    logic               w_collect;
    logic               w_write;
    logic               w_complete;
    logic               w_accept;
    logic [CNT_W-1:0]   w_waddr;
    logic [1:0]         w_full_next;
    logic [COL_LEN*DATA_W-1:0] w_bank_data [2];

    // Handshake: a column transfers on any rising edge where col_valid and col_ready
    // are both high; col_data holds steady from col_valid rising until that edge.
    always_comb begin
        w_burst_start = ((r_state == ST_ARMED) || (r_state == ST_GAP)) && flag_in && !map_finish;
        w_collect     = (r_state == ST_COLLECT) && flag_in && !map_finish;
        w_write       = (w_burst_start && !r_full[r_wr_bank]) || (w_collect && !r_drop);
        w_complete    = w_collect && !r_drop && (r_elem_cnt == LAST_IDX);
        w_accept      = r_full[r_rd_bank] && col_ready;
        w_waddr       = w_collect ? r_elem_cnt : '0;
        w_full_next   = r_full;
        if (w_accept) w_full_next[r_rd_bank] = 1'b0;
        if (w_complete) w_full_next[r_wr_bank] = 1'b1;
    end

    col_bank #(.DATA_W(DATA_W), .COL_LEN(COL_LEN), .ADDR_W(CNT_W)) u_bank0 (
        .clk    (clk),
        .i_we   (w_write && !r_wr_bank),
        .i_addr (w_waddr),
        .i_data (data_in),
        .o_data (w_bank_data[0])
    );

    col_bank #(.DATA_W(DATA_W), .COL_LEN(COL_LEN), .ADDR_W(CNT_W)) u_bank1 (
        .clk    (clk),
        .i_we   (w_write && r_wr_bank),
        .i_addr (w_waddr),
        .i_data (data_in),
        .o_data (w_bank_data[1])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_elem_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_drop      <= 1'b0;
            r_full      <= 2'b00;
            r_col_count <= 16'd0;
            r_short_err <= 1'b0;
            r_gap_err   <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_accept) begin
                r_rd_bank   <= ~r_rd_bank;
                r_col_count <= r_col_count + 16'd1;
            end
            // A dropped burst never occupied a bank, so it must not advance wr_bank.
            if (w_complete) r_wr_bank <= ~r_wr_bank;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_ARMED;
                        r_col_count <= w_accept ? 16'd1 : 16'd0;
                        r_short_err <= 1'b0;
                        r_gap_err   <= 1'b0;
                        r_ovf_err   <= 1'b0;
                    end
                end
                ST_ARMED, ST_GAP: begin
                    if (map_finish) begin
                        r_state <= ST_IDLE;
                    end else if (flag_in) begin
                        if ((r_state == ST_GAP) && (r_gap_cnt < GAP_SAT)) r_gap_err <= 1'b1;
                        if (r_full[r_wr_bank]) r_ovf_err <= 1'b1;
                        r_drop     <= r_full[r_wr_bank];
                        r_elem_cnt <= CNT_W'(1);
                        r_state    <= ST_COLLECT;
                    end else if ((r_state == ST_GAP) && (r_gap_cnt != GAP_SAT)) begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                ST_COLLECT: begin
                    if (map_finish) begin
                        r_short_err <= 1'b1;
                        r_elem_cnt  <= '0;
                        r_state     <= ST_IDLE;
                    end else if (!flag_in) begin
                        r_short_err <= 1'b1;
                        r_elem_cnt  <= '0;
                        r_gap_cnt   <= '0;
                        r_state     <= ST_GAP;
                    end else if (r_elem_cnt == LAST_IDX) begin
                        r_elem_cnt <= '0;
                        r_gap_cnt  <= '0;
                        r_state    <= ST_GAP;
                    end else begin
                        r_elem_cnt <= r_elem_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign col_valid = r_full[r_rd_bank];
    assign col_data  = w_bank_data[r_rd_bank];
    assign col_count = r_col_count;
    assign short_err = r_short_err;
    assign gap_err   = r_gap_err;
    assign ovf_err   = r_ovf_err;
    assign busy      = (r_state != ST_IDLE) || (|r_full);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_col_burst_collector.sv
// Bench for col_burst_collector: hand table, directed corner sequences, random bursts vs a queue model.
module tb_col_burst_collector;
    import img2col_pkg::*;

    localparam int DW = 8;
    localparam int CL = 27;
    localparam int MG = 3;
    localparam int CW = DW * CL;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          map_finish;
    logic          flag_in;
    logic [DW-1:0] data_in;
    logic [CW-1:0] col_data;
    logic          col_valid;
    logic          col_ready;
    logic [15:0]   col_count;
    logic          short_err;
    logic          gap_err;
    logic          ovf_err;
    logic          busy;
    logic [1:0]    dbg_state;

    col_burst_collector #(.DATA_W(DW), .COL_LEN(CL), .MIN_GAP(MG)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .map_finish (map_finish),
        .flag_in    (flag_in),
        .data_in    (data_in),
        .col_data   (col_data),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_count  (col_count),
        .short_err  (short_err),
        .gap_err    (gap_err),
        .ovf_err    (ovf_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: columns waiting downstream live in a queue of at most two.
    col_state_t    m_phase;
    logic [CW-1:0] exp_q[$];
    logic [DW-1:0] m_cur [CL];
    int            m_len;
    int            m_gap;
    bit            m_drop;
    logic [15:0]   m_count;
    bit            m_short;
    bit            m_gap_e;
    bit            m_ovf;
    logic [CW-1:0] got_q[$];

    typedef struct {
        bit         s;
        bit         mf;
        bit         fl;
        bit         rdy;
        col_state_t e_state;
        bit         e_busy;
        bit         e_short;
        bit         e_gap;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = ST_IDLE;
        exp_q.delete();
        m_len   = 0;
        m_gap   = 0;
        m_drop  = 0;
        m_count = 16'd0;
        m_short = 0;
        m_gap_e = 0;
        m_ovf   = 0;
    endtask

    function automatic logic [CW-1:0] pack_cur();
        logic [CW-1:0] v;
        for (int i = 0; i < CL; i++) v[i*DW +: DW] = m_cur[i];
        return v;
    endfunction

    task automatic model_edge(input bit s, input bit mf, input bit fl, input logic [DW-1:0] d, input bit rdy);
        int held;
        bit acc;
        bit done;
        held = exp_q.size();
        acc  = (held > 0) && rdy;
        done = 0;
        case (m_phase)
            ST_IDLE: begin
                if (s) begin
                    m_phase = ST_ARMED;
                    m_count = 16'd0;
                    m_short = 0;
                    m_gap_e = 0;
                    m_ovf   = 0;
                end
            end
            ST_ARMED, ST_GAP: begin
                if (mf) begin
                    m_phase = ST_IDLE;
                end else if (fl) begin
                    if (m_phase == ST_GAP && m_gap < MG) m_gap_e = 1;
                    m_drop = (held == 2);
                    if (m_drop) m_ovf = 1;
                    m_cur[0] = d;
                    m_len    = 1;
                    m_phase  = ST_COLLECT;
                end else if (m_phase == ST_GAP && m_gap < MG) begin
                    m_gap++;
                end
            end
            default: begin
                if (mf) begin
                    m_short = 1;
                    m_phase = ST_IDLE;
                end else if (!fl) begin
                    m_short = 1;
                    m_phase = ST_GAP;
                    m_gap   = 0;
                end else begin
                    m_cur[m_len] = d;
                    m_len++;
                    if (m_len == CL) begin
                        done    = !m_drop;
                        m_phase = ST_GAP;
                        m_gap   = 0;
                    end
                end
            end
        endcase
        if (acc) begin
            void'(exp_q.pop_front());
            m_count++;
        end
        if (done) exp_q.push_back(pack_cur());
    endtask

    task automatic compare_all();
        chk("state", dbg_state, m_phase);
        chk("col_valid", col_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chk("col_data", col_data, exp_q[0]);
        chk("col_count", col_count, m_count);
        chk("short_err", short_err, m_short);
        chk("gap_err", gap_err, m_gap_e);
        chk("ovf_err", ovf_err, m_ovf);
        chk("busy", busy, (m_phase != ST_IDLE) || (exp_q.size() > 0));
    endtask

    task automatic cycle(input bit s, input bit mf, input bit fl, input logic [DW-1:0] d, input bit rdy);
        start      = s;
        map_finish = mf;
        flag_in    = fl;
        data_in    = d;
        col_ready  = rdy;
        if (col_valid && col_ready) got_q.push_back(col_data);
        @(posedge clk);
        model_edge(s, mf, fl, d, rdy);
        #1;
        compare_all();
    endtask

    task automatic burst(input int len, input int base, input bit rdy);
        for (int i = 0; i < len; i++) cycle(0, 0, 1, DW'(base + i), rdy);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, rdy);
    endtask

    task automatic restart();
        cycle(0, 1, 0, '0, 1);
        cycle(1, 0, 0, '0, 1);
        got_q.delete();
    endtask

    task automatic chk_col(input string name, input int k, input int base);
        logic [CW-1:0] col;
        if (k < got_q.size()) begin
            col = got_q[k];
            for (int i = 0; i < CL; i++)
                chk($sformatf("%s_e%0d", name, i), col[i*DW +: DW], DW'(base + i));
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; map_finish = 0; flag_in = 0; data_in = '0; col_ready = 0;
        model_reset();
        #12;
        chk("rst_valid", col_valid, 0);
        chk("rst_count", col_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {short_err, gap_err, ovf_err}, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{0, 0, 0, 1, ST_IDLE,    0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, ST_ARMED,   1, 0, 0};
        tbl[2] = '{0, 0, 1, 1, ST_COLLECT, 1, 0, 0};
        tbl[3] = '{0, 0, 0, 1, ST_GAP,     1, 1, 0};
        tbl[4] = '{0, 0, 1, 1, ST_COLLECT, 1, 1, 1};
        tbl[5] = '{0, 1, 0, 1, ST_IDLE,    0, 1, 1};
        tbl[6] = '{1, 0, 0, 1, ST_ARMED,   1, 0, 0};
        tbl[7] = '{0, 0, 0, 1, ST_ARMED,   1, 0, 0};
        tbl[8] = '{0, 1, 0, 1, ST_IDLE,    0, 0, 0};
        tbl[9] = '{0, 0, 1, 1, ST_IDLE,    0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].s, tbl[i].mf, tbl[i].fl, DW'($urandom), tbl[i].rdy);
            chk($sformatf("tbl%0d_state", i), dbg_state, tbl[i].e_state);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_short", i), short_err, tbl[i].e_short);
            chk($sformatf("tbl%0d_gap", i), gap_err, tbl[i].e_gap);
        end

        // Three clean bursts, values 1..27.
        restart();
        for (int b = 0; b < 3; b++) begin
            burst(CL, 1, 1);
            idle_cycles(3, 1);
        end
        chk("basic_ncols", got_q.size(), 3);
        for (int k = 0; k < 3; k++) chk_col($sformatf("basic_c%0d", k), k, 1);
        chk("basic_count", col_count, 3);
        chk("basic_errs", {short_err, gap_err, ovf_err}, 0);

        // Downstream stalled across three bursts: third is dropped.
        restart();
        burst(CL, 10, 0); idle_cycles(3, 0);
        burst(CL, 40, 0); idle_cycles(3, 0);
        burst(CL, 70, 0); idle_cycles(3, 0);
        chk("ovf_flag", ovf_err, 1);
        chk("ovf_held", col_valid, 1);
        idle_cycles(5, 1);
        chk("ovf_ncols", got_q.size(), 2);
        chk_col("ovf_c0", 0, 10);
        chk_col("ovf_c1", 1, 40);
        chk("ovf_count", col_count, 2);

        // Short burst discarded, next one delivered.
        restart();
        burst(10, 100, 1); idle_cycles(4, 1);
        chk("short_flag", short_err, 1);
        chk("short_ncols", got_q.size(), 0);
        burst(CL, 5, 1); idle_cycles(3, 1);
        chk("short_ncols2", got_q.size(), 1);
        chk_col("short_c0", 0, 5);
        chk("short_nogap", gap_err, 0);

        // One-cycle gap before a burst.
        restart();
        burst(CL, 20, 1); idle_cycles(1, 1);
        burst(CL, 60, 1); idle_cycles(3, 1);
        chk("gap_flag", gap_err, 1);
        chk("gap_ncols", got_q.size(), 2);
        chk_col("gap_c1", 1, 60);

        // map_finish mid-collect with one column pending.
        restart();
        burst(CL, 30, 0); idle_cycles(3, 0);
        burst(10, 90, 0);
        cycle(0, 1, 1, 8'd99, 0);
        chk("mf_state", dbg_state, ST_IDLE);
        chk("mf_short", short_err, 1);
        chk("mf_busy_pend", busy, 1);
        idle_cycles(1, 1);
        chk("mf_ncols", got_q.size(), 1);
        chk_col("mf_c0", 0, 30);
        chk("mf_busy_done", busy, 0);

        // Asynchronous reset in the middle of a burst.
        restart();
        burst(15, 50, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", col_valid, 0);
        chk("arst_count", col_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_errs", {short_err, gap_err, ovf_err}, 0);
        chk("arst_state", dbg_state, ST_IDLE);
        model_reset();
        got_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 0, 0, '0, 1);
        burst(CL, 7, 1); idle_cycles(3, 1);
        chk("arst_ncols", got_q.size(), 1);
        chk_col("arst_c0", 0, 7);

        // Random traffic against the model.
        restart();
        for (int b = 0; b < 80; b++) begin
            int len;
            int gap;
            int rdy_bias;
            len      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, CL + 3)) : CL;
            gap      = $urandom_range(0, 5);
            rdy_bias = $urandom_range(0, 3);
            for (int i = 0; i < len + gap; i++)
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0, i < len,
                      DW'($urandom), $urandom_range(0, 3) < rdy_bias);
        end
        idle_cycles(4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
